// File: rtl/friet_c_stream_pkg.sv
// friet_c_stream_pkg: shared byte-width constants and queue entry packing {last, size, data}
package friet_c_stream_pkg;

    localparam int DIN_BYTES  = 16;
    localparam int DOUT_BYTES = 4;

    function automatic int entry_size_lsb(input int din_width);
        return din_width;
    endfunction

    function automatic int entry_last_bit(input int din_width, input int din_size_width);
        return din_width + din_size_width + 1;
    endfunction

    function automatic int entry_width(input int din_width, input int din_size_width);
        return entry_last_bit(din_width, din_size_width) + 1;
    endfunction

endpackage

// File: rtl/friet_c_stream_fifo_mem.sv
// friet_c_stream_fifo_mem: queue storage, one write port and one asynchronous read port
module friet_c_stream_fifo_mem
    import friet_c_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLOTS = 3,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [SLOTS];

    // Storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/friet_c_stream_buffer_out_fifo.sv
// friet_c_stream_buffer_out_fifo: wide-to-narrow output buffer; define FRIET_C_STREAM_BUFFER_OUT_KEEP_EN for dout_keep
module friet_c_stream_buffer_out_fifo
    import friet_c_stream_pkg::*;
#(
    parameter int DIN_WIDTH       = 8 * DIN_BYTES,
    parameter int DIN_SIZE_WIDTH  = 4,
    parameter int DOUT_WIDTH      = 8 * DOUT_BYTES,
    parameter int DOUT_SIZE_WIDTH = 2,
    parameter int DEPTH           = 4,
    parameter int DEPTH_WIDTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_WIDTH-1:0]       din,
    input  logic [DIN_SIZE_WIDTH:0]    din_size,
    input  logic                       din_last,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DOUT_WIDTH-1:0]      dout,
`ifdef FRIET_C_STREAM_BUFFER_OUT_KEEP_EN
    output logic [DOUT_WIDTH/8-1:0]    dout_keep,
`endif
    output logic [DOUT_SIZE_WIDTH:0]   dout_size,
    output logic                       dout_last,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [DIN_SIZE_WIDTH:0]    size,
    output logic [DEPTH_WIDTH:0]       count
);

    localparam int SW    = DIN_SIZE_WIDTH + 1;
    localparam int OB    = DOUT_WIDTH / 8;
    localparam int IB    = DIN_WIDTH / 8;
    localparam int SLOTS = DEPTH - 1;
    localparam int EW    = entry_width(DIN_WIDTH, DIN_SIZE_WIDTH);
    localparam int SLSB  = entry_size_lsb(DIN_WIDTH);
    localparam int LB    = entry_last_bit(DIN_WIDTH, DIN_SIZE_WIDTH);

    localparam logic [SW-1:0]              OB_S      = SW'(OB);
    localparam logic [SW-1:0]              IB_S      = SW'(IB);
    localparam logic [DOUT_SIZE_WIDTH:0]   DS_MAX    = (DOUT_SIZE_WIDTH+1)'(OB);
    localparam logic [DEPTH_WIDTH:0]       CNT_FULL  = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH-1:0]     LAST_SLOT = DEPTH_WIDTH'(SLOTS - 1);

    logic [DIN_WIDTH-1:0]   head_data_q, head_data_d;
    logic [SW-1:0]          rem_q, rem_d;
    logic                   head_last_q, head_last_d;
    logic                   head_vld_q, head_vld_d;
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   qcnt_q, qcnt_d;

    logic [SW-1:0] din_sz;
    logic [EW-1:0] wr_entry, rd_entry;
    logic          head_fire, head_retire, head_free;
    logic          push, q_empty, q_push, q_pop;

    friet_c_stream_fifo_mem #(
        .WIDTH (EW),
        .SLOTS (SLOTS),
        .AW    (DEPTH_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (q_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Handshakes: the head retires on its final accepted beat, which frees room for din even when full.
    always_comb begin
        din_sz      = din_size > IB_S ? IB_S : din_size;
        head_fire   = head_vld_q & dout_ready;
        head_retire = head_fire & (rem_q <= OB_S);
        head_free   = ~head_vld_q | head_retire;
        count       = (DEPTH_WIDTH+1)'(head_vld_q) + qcnt_q;
        din_ready   = ~rst & ((count < CNT_FULL) | head_retire);
        push        = din_valid & din_ready & ((din_size != '0) | din_last);
        q_empty     = qcnt_q == '0;
        q_pop       = head_free & ~q_empty;
        q_push      = push & ~(head_free & q_empty);
        wr_entry    = {din_last, din_sz, din};
        qcnt_d      = qcnt_q + (DEPTH_WIDTH+1)'(q_push) - (DEPTH_WIDTH+1)'(q_pop);
        wr_ptr_d    = q_push ? (wr_ptr_q == LAST_SLOT ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = q_pop ? (rd_ptr_q == LAST_SLOT ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    end

    // Head register: refill from queue front first, else bypass din; otherwise shift out one beat.
    always_comb begin
        head_data_d = head_data_q;
        rem_d       = rem_q;
        head_last_d = head_last_q;
        head_vld_d  = head_vld_q;
        if (q_pop) begin
            head_data_d = rd_entry[DIN_WIDTH-1:0];
            rem_d       = rd_entry[SLSB +: SW];
            head_last_d = rd_entry[LB];
            head_vld_d  = 1'b1;
        end else if (head_free) begin
            head_data_d = push ? din : '0;
            rem_d       = push ? din_sz : '0;
            head_last_d = push & din_last;
            head_vld_d  = push;
        end else if (head_fire) begin
            head_data_d = head_data_q >> DOUT_WIDTH;
            rem_d       = rem_q - OB_S;
        end
    end

    // State registers, cleared asynchronously so a reset drops every stored word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data_q <= '0;
            rem_q       <= '0;
            head_last_q <= 1'b0;
            head_vld_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            qcnt_q      <= '0;
        end else begin
            head_data_q <= head_data_d;
            rem_q       <= rem_d;
            head_last_q <= head_last_d;
            head_vld_q  <= head_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            qcnt_q      <= qcnt_d;
        end
    end

    // Current beat view of the head word.
    always_comb begin
        dout_valid = head_vld_q;
        dout_size  = rem_q > OB_S ? DS_MAX : rem_q[DOUT_SIZE_WIDTH:0];
        dout_last  = head_last_q & (rem_q <= OB_S);
        size       = rem_q;
    end

`ifdef FRIET_C_STREAM_BUFFER_OUT_KEEP_EN
    // Byte-lane mask; lanes beyond dout_size are driven as zero.
    always_comb begin
        dout_keep = '0;
        dout      = '0;
        for (int i = 0; i < OB; i++) begin
            dout_keep[i]  = i < int'(dout_size);
            dout[8*i +: 8] = dout_keep[i] ? head_data_q[8*i +: 8] : 8'h00;
        end
    end
`else
    // Bytes beyond dout_size are passed through unmasked.
    always_comb begin
        dout = head_data_q[DOUT_WIDTH-1:0];
    end
`endif

endmodule

// File: tb/tb_friet_c_stream_buffer_out_fifo.sv
// tb_friet_c_stream_buffer_out_fifo: directed checks of the wide-to-narrow output buffer
module tb_friet_c_stream_buffer_out_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic [4:0]   din_size;
    logic         din_last, din_valid, din_ready;
    logic [31:0]  dout;
    logic [2:0]   dout_size;
    logic         dout_last, dout_valid, dout_ready;
    logic [4:0]   size;
    logic [2:0]   count;
`ifdef FRIET_C_STREAM_BUFFER_OUT_KEEP_EN
    logic [3:0]   dout_keep;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    friet_c_stream_buffer_out_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_size   (din_size),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
`ifdef FRIET_C_STREAM_BUFFER_OUT_KEEP_EN
        .dout_keep  (dout_keep),
`endif
        .dout_size  (dout_size),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .size       (size),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat(input int k, input int j);
        return 32'hC0DE0000 | 32'(k * 16 + j);
    endfunction

    function automatic logic [127:0] word(input int k);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[32*j +: 32] = beat(k, j);
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic [4:0] s, input logic l);
        din_valid = v;
        din       = d;
        din_size  = s;
        din_last  = l;
    endtask

    initial begin
        logic [127:0] bytes_w;
        bytes_w    = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        rst        = 1'b1;
        dout_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #3;
        chk("rst dout_valid", dout_valid, 0);
        chk("rst count", count, 0);
        chk("rst size", size, 0);
        chk("rst dout_last", dout_last, 0);
        chk("rst dout_size", dout_size, 0);
        chk("rst din_ready", din_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("post-rst din_ready", din_ready, 1);
        tick();

        // T1: full 16-byte word, 4 beats, last only on the 4th
        drive(1'b1, bytes_w, 5'd16, 1'b1);
        chk("t1 din_ready", din_ready, 1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("t1 dout_valid", dout_valid, 1);
        chk("t1 count", count, 1);
        chk("t1 size", size, 16);
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1 dout %0d", k), dout, bytes_w[32*k +: 32]);
            chk($sformatf("t1 dout_size %0d", k), dout_size, 4);
            chk($sformatf("t1 dout_last %0d", k), dout_last, k == 3);
            tick();
        end
        chk("t1 empty", dout_valid, 0);
        chk("t1 count end", count, 0);

        // T2: 6-byte word, beats of 4 then 2
        drive(1'b1, bytes_w, 5'd6, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("t2 b0 dout", dout, 32'h03020100);
        chk("t2 b0 size", dout_size, 4);
        chk("t2 b0 last", dout_last, 0);
        tick();
        chk("t2 b1 dout", dout[15:0], 16'h0504);
        chk("t2 b1 size", dout_size, 2);
        chk("t2 b1 last", dout_last, 1);
        chk("t2 b1 rem", size, 2);
`ifdef FRIET_C_STREAM_BUFFER_OUT_KEEP_EN
        chk("t2 b1 keep", dout_keep, 4'b0011);
        chk("t2 b1 masked", dout, 32'h00000504);
`endif
        tick();
        chk("t2 empty", dout_valid, 0);

        // T3: fill to DEPTH with dout stalled, then pop+push on the retiring beat
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, word(k), 5'd16, 1'b1);
            chk($sformatf("t3 rdy %0d", k), din_ready, 1);
            tick();
        end
        drive(1'b1, word(4), 5'd16, 1'b1);
        chk("t3 full count", count, 4);
        chk("t3 full rdy", din_ready, 0);
        tick();
        chk("t3 stall count", count, 4);
        dout_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t3 w0 b%0d", j), dout, beat(0, j));
            chk($sformatf("t3 rdy b%0d", j), din_ready, j == 3);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("t3 count after swap", count, 4);
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("t3 drain v%0d", c), dout_valid, 1);
            chk($sformatf("t3 drain d%0d", c), dout, beat(1 + c / 4, c % 4));
            tick();
        end
        chk("t3 drained", count, 0);

        // T4: zero-size words
        dout_ready = 1'b0;
        drive(1'b1, '0, 5'd0, 1'b0);
        tick();
        drive(1'b1, '0, 5'd0, 1'b1);
        chk("t4 discard count", count, 0);
        chk("t4 discard valid", dout_valid, 0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("t4 term valid", dout_valid, 1);
        chk("t4 term size", dout_size, 0);
        chk("t4 term last", dout_last, 1);
        chk("t4 term count", count, 1);
        dout_ready = 1'b1;
        tick();
        chk("t4 term gone", dout_valid, 0);

        // T5: three words streamed back to back with no bubble
        drive(1'b1, word(0), 5'd16, 1'b1);
        tick();
        for (int c = 0; c < 12; c++) begin
            if (c < 2) drive(1'b1, word(c + 1), 5'd16, 1'b1);
            else drive(1'b0, '0, '0, 1'b0);
            chk($sformatf("t5 v%0d", c), dout_valid, 1);
            chk($sformatf("t5 d%0d", c), dout, beat(c / 4, c % 4));
            chk($sformatf("t5 l%0d", c), dout_last, c % 4 == 3);
            tick();
        end
        chk("t5 empty", dout_valid, 0);

        // T6: asynchronous reset mid-word, then a clamped-size word
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, word(k), 5'd16, 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("t6 pre count", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst valid", dout_valid, 0);
        chk("t6 rst count", count, 0);
        chk("t6 rst rdy", din_ready, 0);
        #3 rst = 1'b0;
        tick();
        drive(1'b1, word(5), 5'd31, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("t6 clamp size", size, 16);
        chk("t6 count", count, 1);
        dout_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t6 d%0d", j), dout, beat(5, j));
            chk($sformatf("t6 l%0d", j), dout_last, j == 3);
            tick();
        end
        chk("t6 empty", dout_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
